// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit word to 16-bit SRAM controller.
package sram_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned WIDX_W  = SRAM_AW - 1;
  localparam int unsigned CNT_W   = 4;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR   = 32'd1024;
  localparam int unsigned       DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  // Transaction latched in IDLE and replayed over both halfword phases.
  typedef struct packed {
    logic              write;
    logic [WIDX_W-1:0] word_idx;
    logic [WORD_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{default: 1'b1};

  // SRAM word index of a byte address; out-of-range offsets wrap and truncate.
  function automatic logic [WIDX_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                   input logic [WORD_W-1:0] base);
    return WIDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one halfword phase; done_c is high on the last cycle.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/sram_word_controller.sv
// Splits 32-bit MEM-stage reads/writes into low-then-high halfword SRAM phases.
module sram_word_controller
  import sram_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned       WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [WORD_W-1:0]   address,
  input  logic [WORD_W-1:0]   write_data,
  output logic [WORD_W-1:0]   read_data,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  state_e               state_q, state_d;
  req_t                 req_q, req_d;
  strobe_t              strobe_q, strobe_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [WORD_W-1:0]    read_data_q, read_data_d;
  logic                 cnt_load;
  logic                 cnt_done_c;
  logic                 half_c;
  logic                 phase_c;

  sram_wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (CNT_W'(WAIT_CYCLES - 1)),
    .done_c     (cnt_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      strobe_q    <= STROBE_IDLE;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      strobe_q    <= strobe_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      read_data_q <= read_data_d;
    end
  end

  // Next state plus pin values for the state being entered, so pins change with it.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    read_data_d = read_data_q;
    cnt_load    = 1'b0;
    strobe_d    = STROBE_IDLE;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    half_c      = 1'b0;
    phase_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          req_d.write    = wr_en;
          req_d.word_idx = word_index(address, BASE_ADDR);
          req_d.data     = write_data;
          cnt_load       = 1'b1;
          state_d        = LOW;
        end
      end
      LOW: begin
        if (cnt_done_c) begin
          if (!req_q.write) begin
            read_data_d[SRAM_DW-1:0] = SRAM_DQ;
          end
          cnt_load = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (cnt_done_c) begin
          if (!req_q.write) begin
            read_data_d[WORD_W-1:SRAM_DW] = SRAM_DQ;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    phase_c = (state_d == LOW) || (state_d == HIGH);
    half_c  = (state_d == HIGH);
    if (phase_c) begin
      strobe_d.ce_n = 1'b0;
      strobe_d.ub_n = 1'b0;
      strobe_d.lb_n = 1'b0;
      strobe_d.we_n = ~req_d.write;
      strobe_d.oe_n = req_d.write;
      dq_oe_d       = req_d.write;
      sram_addr_d   = {req_d.word_idx, half_c};
      dq_out_d      = half_c ? req_d.data[WORD_W-1:SRAM_DW] : req_d.data[SRAM_DW-1:0];
    end
  end

  assign ready     = ~(rd_en | wr_en) | (state_q == DONE);
  assign read_data = read_data_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = strobe_q.ce_n;
  assign SRAM_WE_N = strobe_q.we_n;
  assign SRAM_OE_N = strobe_q.oe_n;
  assign SRAM_UB_N = strobe_q.ub_n;
  assign SRAM_LB_N = strobe_q.lb_n;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_word_controller.sv
// Scoreboard bench: word-level reference memory vs. pin-level SRAM device model.
module tb_sram_word_controller;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int          N    = 2;

  typedef struct {
    bit          write;
    logic [16:0] idx;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  sram_word_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin-level SRAM device
  logic [15:0] mem [0:262143];
  wire         sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = sram_rd ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
  end

  wire [4:0] strobes = {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N};

  logic [31:0] ref_mem [logic [16:0]];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Issue one word request, hold it until ready, then release at the next edge.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   k;
    e.idx   = 17'((addr - BASE) >> 2);
    e.write = wr;
    if (wr) begin
      e.data = data;
      ref_mem[e.idx] = data;
    end else begin
      e.data = ref_mem.exists(e.idx) ? ref_mem[e.idx] : 32'h0;
    end
    exp_q.push_back(e);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 20);
    check("ready_timeout", 32'(ready), 32'd1);
    if (!ready) finish_run();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: walks each transaction cycle by cycle against the expected item.
  bit   in_txn = 1'b0;
  int   t = 0;
  exp_t cur;
  always @(negedge clk) begin
    logic half;
    if (rst) begin
      in_txn = 1'b0;
    end else if (rd_en || wr_en) begin
      if (!in_txn) begin
        check("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur    = exp_q[0];
          in_txn = 1'b1;
          t      = 0;
        end
      end else begin
        t++;
      end
      if (in_txn) begin
        if (t == 0) begin
          check("c0_ready", 32'(ready), 32'd0);
          check("c0_strobes", 32'(strobes), 32'h1f);
        end else if (t <= 2 * N) begin
          half = (t > N);
          check("ph_ready", 32'(ready), 32'd0);
          check("ph_ce_ub_lb", 32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
          check("ph_we_n", 32'(SRAM_WE_N), 32'(!cur.write));
          check("ph_oe_n", 32'(SRAM_OE_N), 32'(cur.write));
          check("ph_addr", 32'(SRAM_ADDR), 32'({cur.idx, half}));
          if (cur.write)
            check("ph_dq", 32'(SRAM_DQ), 32'(half ? cur.data[31:16] : cur.data[15:0]));
        end else begin
          check("done_ready", 32'(ready), 32'd1);
          check("done_strobes", 32'(strobes), 32'h1f);
          if (!cur.write) check("read_data", read_data, cur.data);
          void'(exp_q.pop_front());
          in_txn = 1'b0;
        end
      end
    end else begin
      check("idle_ready", 32'(ready), 32'd1);
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_strobes", 32'(strobes), 32'h1f);
    rd_en = 1'b1;
    #1 check("rst_ready_req", 32'(ready), 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed scenarios
    txn(0, 1, 32'd1024, 32'hDEADBEEF); idle(1);
    txn(1, 0, 32'd1024, 32'h0);        idle(2);
    txn(0, 1, 32'd1032, 32'h12345678); idle(1);
    txn(0, 1, 32'd1020, 32'hCAFEF00D); idle(1);
    txn(1, 0, 32'd1020, 32'h0);        idle(1);
    txn(1, 1, 32'd1032, 32'hA5A55A5A); idle(1);
    txn(1, 0, 32'd1032, 32'h0);        idle(1);
    // wr_en held through DONE with new data: back-to-back
    txn(0, 1, 32'd1036, 32'h0BADF00D);
    txn(0, 1, 32'd1040, 32'h600DCAFE);
    txn(1, 0, 32'd1036, 32'h0);
    txn(1, 0, 32'd1040, 32'h0);        idle(1);

    // Reset in cycle 3 of a write, after a read left read_data nonzero
    txn(1, 0, 32'd1024, 32'h0);        idle(1);
    begin
      exp_t e;
      e.write = 1'b1; e.idx = 17'd4; e.data = 32'h11112222;
      ref_mem[e.idx] = e.data;
      exp_q.push_back(e);
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1; wr_en = 1'b0;
      #1;
      check("midrst_strobes", 32'(strobes), 32'h1f);
      check("midrst_read_data", read_data, 32'd0);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
    end
    txn(0, 1, 32'd1040, 32'h33334444); idle(1);
    txn(1, 0, 32'd1040, 32'h0);        idle(1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 4);
      if (sel == 0) begin
        a = $urandom;
        a[1:0] = 2'b00;
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 15));
      end
      d = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4)      txn(0, 1, a, d);
      else if (sel < 8) txn(1, 0, a, d);
      else              txn(1, 1, a, d);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule
